// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction port and a data port onto one shared memory port,
// one outstanding transaction at a time, with data priority bounded by a starvation limit.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;

  logic grantData, grantInst, grantAny;

  // Data normally wins; inst is forced once data has been granted LIMIT times over it.
  always_comb begin
    grantData = data_req && !(inst_req && (starve_q == LIMIT));
    grantInst = inst_req && !grantData;
    grantAny  = (state_q == ST_IDLE) && (grantData || grantInst);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_INST;
      starve_q <= '0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'h0;
      wstrb_q  <= 4'h0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grantAny)    state_d = ST_REQ;
      ST_REQ:  if (mem_addr_ok) state_d = ST_WAIT;
      ST_WAIT: if (mem_data_ok) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured at grant so requesters may change inputs freely afterwards.
  always_comb begin
    owner_d  = owner_q;
    starve_d = starve_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    if (grantAny) begin
      if (grantData) begin
        owner_d  = OWN_DATA;
        starve_d = !inst_req ? '0 : (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
        wr_d     = data_wr;
        size_d   = data_size;
        addr_d   = data_addr;
        wstrb_d  = data_wstrb;
        wdata_d  = data_wdata;
      end else begin
        owner_d  = OWN_INST;
        starve_d = '0;
        wr_d     = 1'b0;
        size_d   = 2'b10;
        addr_d   = inst_addr;
        wstrb_d  = 4'h0;
        wdata_d  = 32'h0;
      end
    end
  end

  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    if (!reset) begin
      inst_addr_ok = grantAny && grantInst;
      data_addr_ok = grantAny && grantData;
      mem_req      = (state_q == ST_REQ);
      inst_data_ok = (state_q == ST_WAIT) && mem_data_ok && (owner_q == OWN_INST);
      data_data_ok = (state_q == ST_WAIT) && mem_data_ok && (owner_q == OWN_DATA);
    end
  end

  assign mem_wr     = wr_q;
  assign mem_size   = size_q;
  assign mem_addr   = addr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_wdata  = wdata_q;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, inst read, collision, starvation,
// write field capture and reset abandoning a transaction.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  task automatic checkOutputWord(input string tag, input logic [31:0] observed,
                                 input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Slave accepts in the first REQ cycle and returns data in the following cycle.
  task automatic completeTxn(input logic [31:0] rdata);
    nextCycle();
    mem_addr_ok = 1'b1;
    applyStimulus();
    nextCycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    applyStimulus();
    nextCycle();
    mem_data_ok = 1'b0;
  endtask

  logic expInst [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h0;
    data_wstrb = 4'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    applyStimulus();
    checkOutput("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    checkOutput("rst_data_addr_ok", data_addr_ok, 1'b0);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_inst_data_ok", inst_data_ok, 1'b0);
    checkOutput("rst_data_data_ok", data_data_ok, 1'b0);
    checkOutputWord("rst_mem_addr", mem_addr, 32'h0);
    nextCycle();
    nextCycle();
    inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;
    reset = 1'b0;
    nextCycle();

    $display("[TB] inst read");
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    applyStimulus();
    checkOutput("ird_inst_addr_ok", inst_addr_ok, 1'b1);
    checkOutput("ird_data_addr_ok", data_addr_ok, 1'b0);
    checkOutput("ird_mem_req_n", mem_req, 1'b0);
    nextCycle();
    inst_req = 1'b0; inst_addr = 32'h0; mem_data_ok = 1'b1;
    applyStimulus();
    checkOutput("ird_mem_req_n1", mem_req, 1'b1);
    checkOutputWord("ird_mem_addr", mem_addr, 32'hBFC00000);
    checkOutput("ird_mem_wr", mem_wr, 1'b0);
    checkOutputWord("ird_mem_size", {30'b0, mem_size}, 32'h2);
    checkOutput("ird_dok_ignored_in_req", inst_data_ok, 1'b0);
    nextCycle();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    applyStimulus();
    checkOutput("ird_mem_req_n2", mem_req, 1'b1);
    nextCycle();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h24010001;
    applyStimulus();
    checkOutput("ird_mem_req_wait", mem_req, 1'b0);
    checkOutput("ird_inst_data_ok", inst_data_ok, 1'b1);
    checkOutputWord("ird_inst_rdata", inst_rdata, 32'h24010001);
    checkOutput("ird_data_data_ok", data_data_ok, 1'b0);
    nextCycle();
    mem_data_ok = 1'b0;
    applyStimulus();
    checkOutput("ird_inst_data_ok_drop", inst_data_ok, 1'b0);

    $display("[TB] simultaneous requests");
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_addr = 32'h80000010;
    applyStimulus();
    checkOutput("sim_data_first", data_addr_ok, 1'b1);
    checkOutput("sim_inst_waits", inst_addr_ok, 1'b0);
    nextCycle();
    mem_addr_ok = 1'b1;
    applyStimulus();
    checkOutput("sim_no_addr_ok_req", inst_addr_ok, 1'b0);
    checkOutputWord("sim_mem_addr", mem_addr, 32'h80000010);
    nextCycle();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h11223344;
    applyStimulus();
    checkOutput("sim_data_data_ok", data_data_ok, 1'b1);
    checkOutputWord("sim_data_rdata", data_rdata, 32'h11223344);
    checkOutput("sim_inst_data_ok", inst_data_ok, 1'b0);
    checkOutput("sim_no_addr_ok_wait", inst_addr_ok, 1'b0);
    nextCycle();
    mem_data_ok = 1'b0; data_req = 1'b0;
    applyStimulus();
    checkOutput("sim_inst_granted", inst_addr_ok, 1'b1);
    checkOutput("sim_data_idle", data_addr_ok, 1'b0);
    completeTxn(32'h0);

    $display("[TB] starvation");
    data_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("stv_data_grant", data_addr_ok, !expInst[i]);
      checkOutput("stv_inst_grant", inst_addr_ok, expInst[i]);
      completeTxn(32'h0);
    end
    inst_req = 1'b0; data_req = 1'b0;

    $display("[TB] write capture");
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b00; data_addr = 32'h80001003;
    data_wstrb = 4'b1000; data_wdata = 32'hAB000000;
    applyStimulus();
    checkOutput("wr_data_addr_ok", data_addr_ok, 1'b1);
    nextCycle();
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h0;
    data_wstrb = 4'hF; data_wdata = 32'hFFFFFFFF;
    applyStimulus();
    checkOutput("wr_mem_req", mem_req, 1'b1);
    checkOutput("wr_mem_wr", mem_wr, 1'b1);
    checkOutputWord("wr_mem_size", {30'b0, mem_size}, 32'h0);
    checkOutputWord("wr_mem_addr", mem_addr, 32'h80001003);
    checkOutputWord("wr_mem_wstrb", {28'b0, mem_wstrb}, 32'h8);
    checkOutputWord("wr_mem_wdata", mem_wdata, 32'hAB000000);
    nextCycle();
    mem_addr_ok = 1'b1;
    applyStimulus();
    checkOutputWord("wr_mem_addr_hold", mem_addr, 32'h80001003);
    checkOutputWord("wr_mem_wdata_hold", mem_wdata, 32'hAB000000);
    nextCycle();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    applyStimulus();
    checkOutput("wr_data_data_ok", data_data_ok, 1'b1);
    checkOutput("wr_mem_req_wait", mem_req, 1'b0);
    nextCycle();
    mem_data_ok = 1'b0;

    $display("[TB] reset in wait");
    data_req = 1'b1; data_addr = 32'h80000020;
    applyStimulus();
    checkOutput("rw_grant", data_addr_ok, 1'b1);
    nextCycle();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    applyStimulus();
    nextCycle();
    mem_addr_ok = 1'b0;
    applyStimulus();
    checkOutput("rw_wait_mem_req", mem_req, 1'b0);
    checkOutput("rw_wait_no_dok", data_data_ok, 1'b0);
    reset = 1'b1; mem_data_ok = 1'b1;
    applyStimulus();
    checkOutput("rw_rst_mem_req", mem_req, 1'b0);
    checkOutput("rw_rst_data_dok", data_data_ok, 1'b0);
    checkOutput("rw_rst_inst_dok", inst_data_ok, 1'b0);
    #1 reset = 1'b0;
    nextCycle();
    applyStimulus();
    checkOutput("rw_late_data_dok", data_data_ok, 1'b0);
    checkOutput("rw_late_inst_dok", inst_data_ok, 1'b0);
    mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h80000030;
    applyStimulus();
    checkOutput("rw_regrant", data_addr_ok, 1'b1);
    nextCycle();
    data_req = 1'b0;
    applyStimulus();
    checkOutput("rr_mem_req", mem_req, 1'b1);
    checkOutputWord("rr_mem_addr", mem_addr, 32'h80000030);
    reset = 1'b1;
    applyStimulus();
    checkOutput("rr_rst_mem_req", mem_req, 1'b0);
    checkOutputWord("rr_rst_mem_addr", mem_addr, 32'h0);
    #1 reset = 1'b0;
    nextCycle();
    applyStimulus();
    checkOutput("rr_idle_mem_req", mem_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
